// File: rtl/rv_pkg.sv
// Shared core definitions: PC width and next-PC source encoding.
package rv_pkg;

   localparam int unsigned PC_W = 16;

   typedef enum logic [2:0] {
      SEL_INC,
      SEL_BR,
      SEL_JMP,
      SEL_CALL,
      SEL_RET
   } next_sel_e;

   // Fixed priority: RET > CALL > JMP > BR > increment.
   function automatic next_sel_e next_sel(input logic ret, input logic call,
                                          input logic jmp, input logic br);
      if (ret)       return SEL_RET;
      else if (call) return SEL_CALL;
      else if (jmp)  return SEL_JMP;
      else if (br)   return SEL_BR;
      else           return SEL_INC;
   endfunction

endpackage

// File: rtl/adder_16_bit.sv
// 16-bit ripple-carry adder shared by the ALU and the PC stage.
module adder_16_bit (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        cin,
   output logic [15:0] sum,
   output logic        cout
);

   logic [16:0] c;

   assign c[0] = cin;

   for (genvar i = 0; i < 16; i++) begin : g_fa
      assign sum[i]  = a[i] ^ b[i] ^ c[i];
      assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
   end

   assign cout = c[16];

endmodule

// File: rtl/ras_stack.sv
// Return-address stack: circular buffer with top pointer and saturating count.
module ras_stack
   import rv_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            push,
   input  logic            pop,
   input  logic [PC_W-1:0] push_data,
   output logic [PC_W-1:0] top_data,
   output logic            empty,
   output logic            full
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = PW + 1;

   logic [PC_W-1:0] mem [DEPTH];
   logic [PW-1:0]   top_q, top_d, wr_ptr;
   logic [CW-1:0]   count_q, count_d;

   assign wr_ptr   = top_q + 1'b1;
   assign top_data = mem[top_q];
   assign empty    = (count_q == '0);
   assign full     = (count_q == CW'(DEPTH));

   always_comb begin
      top_d   = top_q;
      count_d = count_q;
      if (push) begin
         // A push when full overwrites the oldest slot, which is wr_ptr.
         top_d = wr_ptr;
         if (!full) count_d = count_q + 1'b1;
      end else if (pop && !empty) begin
         top_d   = top_q - 1'b1;
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         top_q   <= '0;
         count_q <= '0;
      end else begin
         top_q   <= top_d;
         count_q <= count_d;
      end
   end

   // Contents are don't-care after reset, so the storage has no reset.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/pc_unit.sv
// Program-counter stage: next-PC priority select, PC register, RAS and sticky RAS error.
module pc_unit
   import rv_pkg::*;
#(
   parameter logic [15:0] RESET_VEC = 16'h0000,
   parameter int unsigned RAS_DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            en,
   input  logic            br_taken,
   input  logic [PC_W-1:0] br_off,
   input  logic            jmp,
   input  logic            call,
   input  logic            ret,
   input  logic [PC_W-1:0] jmp_addr,
   output logic [PC_W-1:0] pc,
   output logic [PC_W-1:0] pc_plus1,
   output logic            ras_empty,
   output logic            ras_full,
   output logic            ras_err
);

   logic [PC_W-1:0] pc_q, pc_d, br_target, ras_top;
   logic            err_q, err_d;
   logic            push, pop;
   logic            unused_inc_cout, unused_br_cout;
   next_sel_e       sel;

   adder_16_bit u_inc_add (
      .a    (pc_q),
      .b    (16'h0001),
      .cin  (1'b0),
      .sum  (pc_plus1),
      .cout (unused_inc_cout)
   );

   adder_16_bit u_br_add (
      .a    (pc_q),
      .b    (br_off),
      .cin  (1'b0),
      .sum  (br_target),
      .cout (unused_br_cout)
   );

   ras_stack #(
      .DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .pop       (pop),
      .push_data (pc_plus1),
      .top_data  (ras_top),
      .empty     (ras_empty),
      .full      (ras_full)
   );

   assign sel  = next_sel(ret, call, jmp, br_taken);
   assign push = en && (sel == SEL_CALL);
   assign pop  = en && (sel == SEL_RET) && !ras_empty;

   always_comb begin
      pc_d  = pc_q;
      err_d = err_q;
      if (en) begin
         case (sel)
            SEL_RET:  pc_d = ras_empty ? pc_plus1 : ras_top;
            SEL_CALL: pc_d = jmp_addr;
            SEL_JMP:  pc_d = jmp_addr;
            SEL_BR:   pc_d = br_target;
            default:  pc_d = pc_plus1;
         endcase
         // Underflow, CALL+RET conflict and push-when-full are all sticky faults.
         if ((ret && (ras_empty || call)) || (push && ras_full)) err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q  <= RESET_VEC;
         err_q <= 1'b0;
      end else begin
         pc_q  <= pc_d;
         err_q <= err_d;
      end
   end

   assign pc      = pc_q;
   assign ras_err = err_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit.
module tb_pc_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic        br_taken;
   logic [15:0] br_off;
   logic        jmp;
   logic        call;
   logic        ret;
   logic [15:0] jmp_addr;
   logic [15:0] pc;
   logic [15:0] pc_plus1;
   logic        ras_empty;
   logic        ras_full;
   logic        ras_err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pc_unit #(
      .RESET_VEC (16'h0000),
      .RAS_DEPTH (4)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .br_taken  (br_taken),
      .br_off    (br_off),
      .jmp       (jmp),
      .call      (call),
      .ret       (ret),
      .jmp_addr  (jmp_addr),
      .pc        (pc),
      .pc_plus1  (pc_plus1),
      .ras_empty (ras_empty),
      .ras_full  (ras_full),
      .ras_err   (ras_err)
   );

   task automatic idle();
      br_taken = 1'b0;
      br_off   = 16'h0000;
      jmp      = 1'b0;
      call     = 1'b0;
      ret      = 1'b0;
      jmp_addr = 16'h0000;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      idle();
      en    = 1'b1;
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      en = 1'b1;
      idle();
      rst_n = 1'b0;
      step();
      checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL reset_pc: got %h want 0000", pc); end
      checks++; if (pc_plus1 !== 16'h0001) begin errors++; $display("FAIL reset_pc_plus1: got %h want 0001", pc_plus1); end
      checks++; if ({ras_empty, ras_full, ras_err} !== 3'b100) begin errors++; $display("FAIL reset_flags: got %b want 100", {ras_empty, ras_full, ras_err}); end
      rst_n = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         step();
         checks++; if (pc !== 16'(i)) begin errors++; $display("FAIL inc_%0d: got %h want %h", i, pc, 16'(i)); end
      end
      // Stall with a jump request present: everything must hold.
      en = 1'b0; jmp = 1'b1; jmp_addr = 16'h7777;
      step(); step();
      checks++; if (pc !== 16'h0003) begin errors++; $display("FAIL stall_hold: got %h want 0003", pc); end
      idle(); en = 1'b1;
   endtask

   task automatic test_branch_wrap();
      jmp = 1'b1; jmp_addr = 16'h0005; step(); idle();
      checks++; if (pc !== 16'h0005) begin errors++; $display("FAIL jmp_5: got %h want 0005", pc); end
      br_taken = 1'b1; br_off = 16'hFFFB; step(); idle();
      checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL br_back_wrap: got %h want 0000", pc); end
      br_taken = 1'b1; br_off = 16'hFFF0; step(); idle();
      checks++; if (pc !== 16'hFFF0) begin errors++; $display("FAIL br_under_zero: got %h want fff0", pc); end
      br_taken = 1'b1; br_off = 16'h0020; step(); idle();
      checks++; if (pc !== 16'h0010) begin errors++; $display("FAIL br_fwd_wrap: got %h want 0010", pc); end
      jmp = 1'b1; jmp_addr = 16'hFFFF; step(); idle();
      checks++; if (pc_plus1 !== 16'h0000) begin errors++; $display("FAIL plus1_wrap: got %h want 0000", pc_plus1); end
      step();
      checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL inc_wrap: got %h want 0000", pc); end
   endtask

   task automatic test_priority();
      jmp = 1'b1; br_taken = 1'b1; br_off = 16'h0100; jmp_addr = 16'h1234; step(); idle();
      checks++; if (pc !== 16'h1234) begin errors++; $display("FAIL jmp_over_br: got %h want 1234", pc); end
      checks++; if (ras_err !== 1'b0) begin errors++; $display("FAIL err_clean: got %b want 0", ras_err); end
      call = 1'b1; ret = 1'b1; jmp_addr = 16'h4444; step(); idle();
      checks++; if (pc !== 16'h1235) begin errors++; $display("FAIL callret_pc: got %h want 1235", pc); end
      checks++; if ({ras_empty, ras_err} !== 2'b11) begin errors++; $display("FAIL callret_flags: got %b want 11", {ras_empty, ras_err}); end
      step();
      checks++; if (ras_err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b want 1", ras_err); end
   endtask

   task automatic test_call_nesting();
      do_reset();
      jmp = 1'b1; jmp_addr = 16'h0010; step(); idle();
      call = 1'b1; jmp_addr = 16'h0100; step();
      jmp_addr = 16'h0200; step();
      jmp_addr = 16'h0300; step(); idle();
      checks++; if (pc !== 16'h0300) begin errors++; $display("FAIL call3_pc: got %h want 0300", pc); end
      checks++; if ({ras_empty, ras_full} !== 2'b00) begin errors++; $display("FAIL call3_flags: got %b want 00", {ras_empty, ras_full}); end
      ret = 1'b1; step();
      checks++; if (pc !== 16'h0201) begin errors++; $display("FAIL ret1: got %h want 0201", pc); end
      step();
      checks++; if (pc !== 16'h0101) begin errors++; $display("FAIL ret2: got %h want 0101", pc); end
      step(); idle();
      checks++; if (pc !== 16'h0011) begin errors++; $display("FAIL ret3: got %h want 0011", pc); end
      checks++; if ({ras_empty, ras_err} !== 2'b10) begin errors++; $display("FAIL nest_flags: got %b want 10", {ras_empty, ras_err}); end
   endtask

   task automatic test_back_to_back();
      call = 1'b1; jmp_addr = 16'h0500; step(); idle();
      ret = 1'b1; step(); idle();
      checks++; if (pc !== 16'h0012) begin errors++; $display("FAIL call_then_ret: got %h want 0012", pc); end
      checks++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL b2b_empty: got %b want 1", ras_empty); end
   endtask

   task automatic test_overflow();
      logic [15:0] exp_ret [4] = '{16'h0005, 16'h0004, 16'h0003, 16'h0002};
      do_reset();
      for (int i = 1; i <= 5; i++) begin
         call = 1'b1; jmp_addr = 16'(i); step();
         if (i == 4) begin
            checks++; if ({ras_full, ras_err} !== 2'b10) begin errors++; $display("FAIL fill4_flags: got %b want 10", {ras_full, ras_err}); end
         end
      end
      idle();
      checks++; if (pc !== 16'h0005) begin errors++; $display("FAIL call5_pc: got %h want 0005", pc); end
      checks++; if ({ras_full, ras_err} !== 2'b11) begin errors++; $display("FAIL overflow_flags: got %b want 11", {ras_full, ras_err}); end
      ret = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         checks++; if (pc !== exp_ret[i]) begin errors++; $display("FAIL ovf_ret%0d: got %h want %h", i, pc, exp_ret[i]); end
      end
      checks++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL drained_empty: got %b want 1", ras_empty); end
      step(); idle();
      checks++; if (pc !== 16'h0003) begin errors++; $display("FAIL underflow_pc: got %h want 0003", pc); end
      checks++; if ({ras_empty, ras_err} !== 2'b11) begin errors++; $display("FAIL underflow_flags: got %b want 11", {ras_empty, ras_err}); end
   endtask

   task automatic test_async_reset();
      // ras_err is still set from the overflow scenario.
      call = 1'b1; jmp_addr = 16'h0040; step();
      jmp_addr = 16'h0080; step(); idle();
      checks++; if ({pc, ras_empty} !== {16'h0080, 1'b0}) begin errors++; $display("FAIL pre_reset: got %h/%b want 0080/0", pc, ras_empty); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL async_pc: got %h want 0000", pc); end
      checks++; if ({ras_empty, ras_full, ras_err} !== 3'b100) begin errors++; $display("FAIL async_flags: got %b want 100", {ras_empty, ras_full, ras_err}); end
      #1 rst_n = 1'b1;
      step();
      checks++; if (pc !== 16'h0001) begin errors++; $display("FAIL post_reset_inc: got %h want 0001", pc); end
   endtask

   initial begin
      test_reset();
      test_branch_wrap();
      test_priority();
      test_call_nesting();
      test_back_to_back();
      test_overflow();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pc_unit.md
# pc_unit

Program-counter stage for the single-cycle RISC core, upstream of instruction fetch. It holds the 16-bit word-addressed PC and selects next-PC from these sources: sequential increment, PC-relative branch, absolute jump, and call/return through a small return-address stack (RAS). Both increment and branch-target arithmetic use the existing 16-bit ripple adder, so next-PC comes from the same datapath primitive as the ALU.

## Interface
- RESET_VEC, 16'h0000, PC value loaded on reset
- RAS_DEPTH, 4, return-address stack entries (power of two, 2..16)

- CLK  input  1  rising-edge clock
- RST_N  input  1  asynchronous active-low reset
- EN  input  1  advance enable; 0 = stall, all state held
- BR_TAKEN  input  1  take PC-relative branch this cycle
- BR_OFF  input  16  signed branch offset, two's complement, in words
- JMP  input  1  absolute jump to JMP_ADDR
- CALL  input  1  push return address, jump to JMP_ADDR
- RET  input  1  pop return address into PC
- JMP_ADDR  input  16  target for JMP/CALL
- PC  output  16  current program counter (registered)
- PC_PLUS1  output  16  PC+1 (combinational, for link/writeback)
- RAS_EMPTY  output  1  stack holds 0 entries
- RAS_FULL  output  1  stack holds RAS_DEPTH entries
- RAS_ERR  output  1  sticky flag: overflow, underflow or CALL+RET conflict

## Operation
- Reset (RST_N=0, asynchronous): PC=RESET_VEC, stack count=0, RAS_EMPTY=1, RAS_FULL=0, RAS_ERR=0; stack contents don't-care.
- When EN=0, PC, stack and RAS_ERR hold; all control inputs are ignored.
- When EN=1, next-PC priority is highest first:
  - RET: stack non-empty → PC=top, pop. Stack empty → PC=PC+1, set RAS_ERR.
  - CALL: push PC+1, PC=JMP_ADDR.
  - JMP: PC=JMP_ADDR.
  - BR_TAKEN: PC=PC+BR_OFF.
  - Otherwise: PC=PC+1.
- CALL and RET together: RET is performed, CALL is ignored with no push, and RAS_ERR is set.
- A lower-priority request asserted alongside a higher one is dropped silently, except the CALL+RET case above.
- Arithmetic is modulo 2^16 with no overflow flag:
  - PC 16'hFFFF increments to 16'h0000.
  - A branch wraps in either direction.
  - Adder Cin=0; Cout is unused.
- RAS is a circular buffer with a top pointer and a saturating count.
  - Push when full overwrites the oldest entry; count stays at RAS_DEPTH and RAS_ERR is set.
  - Pop decrements count.
  - RAS_FULL and RAS_EMPTY are decoded from count.
- RAS_ERR clears only on reset.

## Timing
- Single clock. All state updates on the rising CLK edge when EN=1.
- Next-PC is combinational from current inputs. The new PC is visible one cycle after the request is sampled.
- PC_PLUS1 tracks PC combinationally in the same cycle.
- RAS_EMPTY and RAS_FULL update on the same edge as the push or pop.
- RAS_ERR asserts on the edge that commits the faulting operation.
- A reset asserted mid-operation takes effect immediately, independent of CLK and EN. The first edge after RST_N rises uses PC=RESET_VEC as its base.
- A CALL followed directly by a RET returns to the CALL address+1, i.e. there is no forwarding hazard.

## Structure
- A shared package `rv_pkg` holds PC_W=16 and the next-PC select encoding (SEL_INC, SEL_BR, SEL_JMP, SEL_CALL, SEL_RET).
- The existing `adder_16_bit` is instantiated twice: PC+1 with B=16'h0001, and PC+BR_OFF.
- A natural sub-module `ras_stack` contains the storage, pointer, count, full/empty flags and push/pop.
- The top level contains the priority select, the PC register and RAS_ERR.

## Test plan
- **Reset and increment:** RST_N low then high, EN=1, no control asserted → PC 0000, 0001, 0002, 0003 on successive edges. Hold EN=0 for 2 cycles → PC stays 0003.
- **Branch wrap:** at PC=0005, BR_TAKEN=1 with BR_OFF=16'hFFFB → PC=0000. At PC=FFFF with no control → PC=0000.
- **Priority:** JMP=1, BR_TAKEN=1, JMP_ADDR=1234 → PC=1234. CALL=1 with RET=1 on an empty stack → PC=PC+1, RAS_ERR=1, no push.
- **Call/return nesting:** CALLs at PC=0010, 0100 and 0200 to 0100, 0200 and 0300, then three RETs → PC 0201, 0101, 0011. RAS_EMPTY=1 at the end, RAS_ERR=0.
- **Overflow/underflow:**
  - Five CALLs from PC=0000, 0001, 0002, 0003, 0004 with DEPTH=4 → RAS_FULL=1 and RAS_ERR=1.
  - Then four RETs → 0005, 0004, 0003, 0002 (the oldest entry was lost).
  - A fifth RET → PC=0003, RAS_EMPTY=1.
- **Async reset mid-stack:** after two CALLs, pulse RST_N low between edges → PC=RESET_VEC immediately, RAS_EMPTY=1, RAS_ERR=0.
